// File: rtl/seg7_capture.sv
// seg7_capture: recovers a 4-digit hex value from a multiplexed 7-segment display bus.
// Optional feature: define SEG7_CAP_ERR_EN to flag undecodable segment patterns on seg_err.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg7_7bit,
    input  logic [3:0]  seg7_an,
    input  logic        seg7_dp,
    output logic [15:0] value,
    output logic [3:0]  dp_mask,
    output logic [3:0]  blank_mask,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        seg_err
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DIG_N  = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;

    // Active-high segment pattern -> {blank, nibble}; unknown patterns give nibble 0, not blank.
    function automatic logic [NIB_W:0] seg_decode(input logic [SEG_W-1:0] s);
        case (s)
            7'h3F:   return 5'h00;
            7'h06:   return 5'h01;
            7'h5B:   return 5'h02;
            7'h4F:   return 5'h03;
            7'h66:   return 5'h04;
            7'h6D:   return 5'h05;
            7'h7D:   return 5'h06;
            7'h07:   return 5'h07;
            7'h7F:   return 5'h08;
            7'h6F:   return 5'h09;
            7'h77:   return 5'h0A;
            7'h7C:   return 5'h0B;
            7'h39:   return 5'h0C;
            7'h5E:   return 5'h0D;
            7'h79:   return 5'h0E;
            7'h71:   return 5'h0F;
            7'h00:   return 5'h10;
            default: return 5'h00;
        endcase
    endfunction

`ifdef SEG7_CAP_ERR_EN
    // True for every pattern the decoder recognises, including the blank digit.
    function automatic logic seg_known(input logic [SEG_W-1:0] s);
        case (s)
            7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
            7'h00:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Raw input register and the previous registered sample
    logic [3:0]       an_q, prev_an_q;
    logic [SEG_W-1:0] seg_q, prev_seg_q;
    logic             dp_q, prev_dp_q;

    // Dwell tracking
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Staging and frame state
    logic [DIG_N-1:0][NIB_W-1:0] stage_nib_q, stage_nib_d;
    logic [DIG_N-1:0] stage_dp_q, stage_dp_d;
    logic [DIG_N-1:0] stage_blank_q, stage_blank_d;
    logic [DIG_N-1:0] seen_q, seen_d;
    logic             done_q, done_d;
    logic             has_frame_q, has_frame_d;

    // Output registers
    logic [15:0]      value_q, value_d;
    logic [DIG_N-1:0] dp_mask_q, dp_mask_d;
    logic [DIG_N-1:0] blank_mask_q, blank_mask_d;
    logic             fv_q, fv_d;
    logic             fc_q, fc_d;

    // Normalised (active-high) view of the registered sample
    logic [3:0]       an_n;
    logic [SEG_W-1:0] seg_n;
    logic             dp_n;
    logic             onehot;
    logic             same;
    logic             capture;
    logic [1:0]       dig;
    logic [NIB_W:0]   dec;

    assign an_n  = AN_ACTIVE_LOW  ? ~an_q  : an_q;
    assign seg_n = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp_n  = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;

    assign onehot  = (an_n != 4'b0000) && ((an_n & (an_n - 4'd1)) == 4'b0000);
    assign same    = ({an_q, seg_q, dp_q} == {prev_an_q, prev_seg_q, prev_dp_q});
    assign capture = onehot && same && (cnt_q == CNT_W'(STABLE_CYCLES - 2));
    assign dec     = seg_decode(seg_n);

    // Selected digit index from the one-hot anode
    always_comb begin
        dig = 2'd0;
        for (int i = 0; i < int'(DIG_N); i++) begin
            if (an_n[i]) dig = 2'(i);
        end
    end

    // Stability counter: saturating count of identical eligible samples
    always_comb begin
        cnt_d = '0;
        if (onehot && same) begin
            if (cnt_q < CNT_W'(STABLE_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
            else                               cnt_d = cnt_q;
        end
    end

    // Staging, frame completion and output update
    always_comb begin
        stage_nib_d   = stage_nib_q;
        stage_dp_d    = stage_dp_q;
        stage_blank_d = stage_blank_q;
        seen_d        = done_q ? '0 : seen_q;
        done_d        = 1'b0;
        has_frame_d   = has_frame_q;
        value_d       = value_q;
        dp_mask_d     = dp_mask_q;
        blank_mask_d  = blank_mask_q;
        fv_d          = 1'b0;
        fc_d          = 1'b0;

        if (done_q) begin
            value_d      = stage_nib_q;
            dp_mask_d    = stage_dp_q;
            blank_mask_d = stage_blank_q;
            fv_d         = 1'b1;
            fc_d         = has_frame_q && ((stage_nib_q != value_q) || (stage_dp_q != dp_mask_q));
            has_frame_d  = 1'b1;
        end

        // A capture on the completion cycle starts the next frame since seen was cleared above
        if (capture) begin
            stage_nib_d[dig]   = dec[NIB_W-1:0];
            stage_dp_d[dig]    = dp_n;
            stage_blank_d[dig] = dec[NIB_W];
            seen_d[dig]        = 1'b1;
            done_d             = (seen_d == 4'b1111);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q          <= '0;
            seg_q         <= '0;
            dp_q          <= 1'b0;
            prev_an_q     <= '0;
            prev_seg_q    <= '0;
            prev_dp_q     <= 1'b0;
            cnt_q         <= '0;
            stage_nib_q   <= '0;
            stage_dp_q    <= '0;
            stage_blank_q <= '0;
            seen_q        <= '0;
            done_q        <= 1'b0;
            has_frame_q   <= 1'b0;
            value_q       <= '0;
            dp_mask_q     <= '0;
            blank_mask_q  <= '0;
            fv_q          <= 1'b0;
            fc_q          <= 1'b0;
        end else begin
            an_q          <= seg7_an;
            seg_q         <= seg7_7bit;
            dp_q          <= seg7_dp;
            prev_an_q     <= an_q;
            prev_seg_q    <= seg_q;
            prev_dp_q     <= dp_q;
            cnt_q         <= cnt_d;
            stage_nib_q   <= stage_nib_d;
            stage_dp_q    <= stage_dp_d;
            stage_blank_q <= stage_blank_d;
            seen_q        <= seen_d;
            done_q        <= done_d;
            has_frame_q   <= has_frame_d;
            value_q       <= value_d;
            dp_mask_q     <= dp_mask_d;
            blank_mask_q  <= blank_mask_d;
            fv_q          <= fv_d;
            fc_q          <= fc_d;
        end
    end

`ifdef SEG7_CAP_ERR_EN
    logic err_q, err_d;

    // Sticky error on capture of an unrecognised pattern
    always_comb begin
        err_d = err_q | (capture & ~seg_known(seg_n));
    end

    // Error flag register
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign seg_err = err_q;
`else
    assign seg_err = 1'b0;
`endif

    assign value         = value_q;
    assign dp_mask       = dp_mask_q;
    assign blank_mask    = blank_mask_q;
    assign frame_valid   = fv_q;
    assign frame_changed = fc_q;

endmodule
